i2c_target_core: RTL and testbench

//  I2C target (slave) byte engine; the responder end of the I2C bus in the Avalon I2C subsystem.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_target_core_if.sv | 12 +
 rtl/i2c_line_sync.sv | 60 ++++++
 rtl/i2c_target_core.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_target_core.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target core.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK,
    IGNORE
  } i2c_tgt_state_t;

  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;
  localparam int   ADDR_W = 7;

  // Bit counter that sticks at 8 once a full byte has been clocked.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= 4'd8) ? 4'd8 : v + 4'd1;
  endfunction

endpackage

// File: rtl/i2c_target_core_if.sv
// Register-side byte handshake of the I2C target core.
interface i2c_target_core_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_valid;

  modport master (input rx_data, rx_valid, tx_req, output rx_ready, tx_data, tx_valid);
  modport slave  (output rx_data, rx_valid, tx_req, input rx_ready, tx_data, tx_valid);
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizer plus stability filter for one open-drain line; emits the
// accepted level and single-cycle rise/fall strobes.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CYC  = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CNT_W = $clog2(FILTER_CYC + 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   level_r;
  logic                   rise_r;
  logic                   fall_r;
  logic                   synced_s;

  assign synced_s = sync_r[SYNC_STAGES-1];

  // Synchronizer chain; idle bus level is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
    end
  end

  // A new level is accepted only after FILTER_CYC consecutive differing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r   <= '0;
      level_r <= 1'b1;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      if (synced_s == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_W'(FILTER_CYC - 1)) begin
        cnt_r   <= '0;
        level_r <= synced_s;
        rise_r  <= synced_s;
        fall_r  <= ~synced_s;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign level = level_r;
  assign rise  = rise_r;
  assign fall  = fall_r;
endmodule

// File: rtl/i2c_target_core.sv
// I2C target byte engine: address match, byte receive/transmit, open-drain drive.
// Optional clock stretching is built when I2C_TARGET_STRETCH_EN is defined.
module i2c_target_core
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CYC  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] own_addr,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              scl_oe,
  output logic              addressed,
  output logic              rd_nwr,
  output logic              start_det,
  output logic              stop_det,
  i2c_target_core_if.slave  hs
);
  logic scl_lvl_s, scl_rise_s, scl_fall_s;
  logic sda_lvl_s, sda_rise_s, sda_fall_s;
  logic start_s, stop_s;

  i2c_tgt_state_t state_r;
  logic [3:0] bit_cnt_r;
  logic [7:0] shift_r, rx_data_r;
  logic sda_oe_r, scl_oe_r, addressed_r, rd_nwr_r, start_det_r, stop_det_r;
  logic rx_pend_r, rx_valid_r, tx_req_r, load_pend_r, ack_pend_r, ack_ok_r;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYC(FILTER_CYC)) u_scl_sync (
    .clk(clk), .reset_n(reset_n), .din(scl_i),
    .level(scl_lvl_s), .rise(scl_rise_s), .fall(scl_fall_s));

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYC(FILTER_CYC)) u_sda_sync (
    .clk(clk), .reset_n(reset_n), .din(sda_i),
    .level(sda_lvl_s), .rise(sda_rise_s), .fall(sda_fall_s));

  assign start_s = sda_fall_s & scl_lvl_s;
  assign stop_s  = sda_rise_s & scl_lvl_s;

  // Protocol FSM; START/STOP take priority over bit strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 4'd0;
      shift_r     <= 8'h00;
      rx_data_r   <= 8'h00;
      sda_oe_r    <= 1'b0;
      scl_oe_r    <= 1'b0;
      addressed_r <= 1'b0;
      rd_nwr_r    <= 1'b0;
      start_det_r <= 1'b0;
      stop_det_r  <= 1'b0;
      rx_pend_r   <= 1'b0;
      rx_valid_r  <= 1'b0;
      tx_req_r    <= 1'b0;
      load_pend_r <= 1'b0;
      ack_pend_r  <= 1'b0;
      ack_ok_r    <= 1'b0;
    end else begin
      start_det_r <= 1'b0;
      stop_det_r  <= 1'b0;
      tx_req_r    <= 1'b0;
      rx_pend_r   <= 1'b0;
      rx_valid_r  <= rx_pend_r;
      if (!enable) begin
        state_r     <= IDLE;
        sda_oe_r    <= 1'b0;
        scl_oe_r    <= 1'b0;
        addressed_r <= 1'b0;
        bit_cnt_r   <= 4'd0;
        rx_valid_r  <= 1'b0;
        load_pend_r <= 1'b0;
        ack_pend_r  <= 1'b0;
        ack_ok_r    <= 1'b0;
      end else if (start_s || stop_s) begin
        state_r     <= start_s ? ADDR : IDLE;
        start_det_r <= start_s;
        stop_det_r  <= ~start_s;
        bit_cnt_r   <= 4'd0;
        sda_oe_r    <= 1'b0;
        scl_oe_r    <= 1'b0;
        addressed_r <= 1'b0;
        load_pend_r <= 1'b0;
        ack_pend_r  <= 1'b0;
        ack_ok_r    <= 1'b0;
      end else begin
`ifdef I2C_TARGET_STRETCH_EN
        // SDA is settled one cycle before the stretch is let go.
        if (scl_oe_r && !load_pend_r && !ack_pend_r) begin
          scl_oe_r <= 1'b0;
        end
`endif
        case (state_r)
          IDLE, IGNORE: begin
          end
          ADDR: begin
            if (scl_rise_s) begin
              shift_r   <= {shift_r[6:0], sda_lvl_s};
              bit_cnt_r <= sat_inc(bit_cnt_r);
            end else if (scl_fall_s && bit_cnt_r == 4'd8) begin
              if (shift_r[7:1] == own_addr) begin
                state_r     <= ADDR_ACK;
                sda_oe_r    <= ~ACK;
                addressed_r <= 1'b1;
                rd_nwr_r    <= shift_r[0];
              end else begin
                state_r <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall_s) begin
              sda_oe_r  <= 1'b0;
              bit_cnt_r <= 4'd0;
              if (rd_nwr_r) begin
                state_r     <= TX;
                tx_req_r    <= 1'b1;
                load_pend_r <= 1'b1;
`ifdef I2C_TARGET_STRETCH_EN
                scl_oe_r    <= 1'b1;
`endif
              end else begin
                state_r <= RX;
              end
            end
          end
          RX: begin
            if (scl_rise_s) begin
              shift_r   <= {shift_r[6:0], sda_lvl_s};
              bit_cnt_r <= sat_inc(bit_cnt_r);
              if (bit_cnt_r == 4'd7) begin
                rx_data_r <= {shift_r[6:0], sda_lvl_s};
                rx_pend_r <= 1'b1;
              end
            end else if (scl_fall_s && bit_cnt_r == 4'd8) begin
              state_r <= RX_ACK;
`ifdef I2C_TARGET_STRETCH_EN
              scl_oe_r   <= 1'b1;
              ack_pend_r <= 1'b1;
`else
              sda_oe_r   <= hs.rx_ready;
`endif
            end
          end
          RX_ACK: begin
            if (ack_pend_r) begin
              if (hs.rx_ready) begin
                sda_oe_r   <= ~ACK;
                ack_pend_r <= 1'b0;
              end
            end else if (scl_fall_s) begin
              sda_oe_r  <= 1'b0;
              bit_cnt_r <= 4'd0;
              state_r   <= RX;
            end
          end
          TX: begin
            if (load_pend_r) begin
`ifdef I2C_TARGET_STRETCH_EN
              if (hs.tx_valid) begin
                shift_r     <= hs.tx_data;
                sda_oe_r    <= ~hs.tx_data[7];
                load_pend_r <= 1'b0;
              end
`else
              shift_r     <= hs.tx_data;
              sda_oe_r    <= ~hs.tx_data[7];
              load_pend_r <= 1'b0;
`endif
            end else if (scl_rise_s) begin
              bit_cnt_r <= sat_inc(bit_cnt_r);
            end else if (scl_fall_s) begin
              if (bit_cnt_r == 4'd8) begin
                sda_oe_r <= 1'b0;
                ack_ok_r <= 1'b0;
                state_r  <= TX_ACK;
              end else begin
                shift_r  <= {shift_r[6:0], 1'b0};
                sda_oe_r <= ~shift_r[6];
              end
            end
          end
          TX_ACK: begin
            if (scl_rise_s) begin
              if (sda_lvl_s == ACK) begin
                ack_ok_r <= 1'b1;
                tx_req_r <= 1'b1;
              end else begin
                state_r     <= IGNORE;
                addressed_r <= 1'b0;
              end
            end else if (scl_fall_s && ack_ok_r) begin
              state_r     <= TX;
              bit_cnt_r   <= 4'd0;
              load_pend_r <= 1'b1;
              ack_ok_r    <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
              scl_oe_r    <= 1'b1;
`endif
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  assign sda_oe      = sda_oe_r;
  assign scl_oe      = scl_oe_r;
  assign addressed   = addressed_r;
  assign rd_nwr      = rd_nwr_r;
  assign start_det   = start_det_r;
  assign stop_det    = stop_det_r;
  assign hs.rx_data  = rx_data_r;
  assign hs.rx_valid = rx_valid_r;
  assign hs.tx_req   = tx_req_r;
endmodule

// File: tb/tb_i2c_target_core.sv
// Self-checking bench: bit-banged I2C controller against a transaction-level model.
module tb_i2c_target_core;
  localparam int H = 20;
  localparam int Q = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic [6:0] own_addr = 7'h00;
  logic scl_drv = 1'b1, sda_drv = 1'b1;
  logic scl_i, sda_i;
  logic sda_oe, scl_oe, addressed, rd_nwr, start_det, stop_det;
  int checks = 0, failures = 0;

  i2c_target_core_if hs();

  assign scl_i = scl_drv & ~scl_oe;
  assign sda_i = sda_drv & ~sda_oe;

  i2c_target_core #(.SYNC_STAGES(2), .FILTER_CYC(3)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .own_addr(own_addr),
    .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe), .scl_oe(scl_oe),
    .addressed(addressed), .rd_nwr(rd_nwr), .start_det(start_det),
    .stop_det(stop_det), .hs(hs));

  always #5 clk = ~clk;

  // Bus monitor: event counters and an SDA-while-SCL-high watchdog.
  int n_txreq = 0, n_start = 0, n_stop = 0, n_sda = 0, n_addr = 0, n_viol = 0;
  int run = 0, max_run = 0;
  logic [7:0] rx_log[$];
  logic sda_oe_q = 1'b0, scl_q = 1'b1;
  always @(negedge clk) begin
    if (hs.rx_valid) rx_log.push_back(hs.rx_data);
    if (hs.tx_req) n_txreq++;
    if (start_det) n_start++;
    if (stop_det) n_stop++;
    if (sda_oe) n_sda++;
    if (addressed) n_addr++;
    if (scl_oe) begin
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (sda_oe !== sda_oe_q && scl_i && scl_q) n_viol++;
    sda_oe_q = sda_oe;
    scl_q = scl_i;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_release();
    int t = 0;
    scl_drv = 1'b1;
    tick(1);
    while (scl_i !== 1'b1 && t < 5000) begin
      tick(1);
      t++;
    end
    checks++;
    if (scl_i !== 1'b1) begin
      failures++;
      $display("FAIL scl_release: scl_i=%b after %0d clk, expected 1", scl_i, t);
    end
  endtask

  task automatic clock_bit(input logic b, output logic r);
    tick(Q);
    sda_drv = b;
    tick(H - Q);
    scl_release();
    tick(H / 2);
    r = sda_i;
    tick(H / 2);
    scl_drv = 1'b0;
  endtask

  task automatic start_cond();
    tick(Q);
    sda_drv = 1'b1;
    tick(H);
    scl_release();
    tick(H);
    sda_drv = 1'b0;
    tick(H);
    scl_drv = 1'b0;
  endtask

  task automatic stop_cond();
    tick(Q);
    sda_drv = 1'b0;
    tick(H);
    scl_release();
    tick(H);
    sda_drv = 1'b1;
    tick(H);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, input logic [7:0] next_tx, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      d[i] = r;
    end
    hs.tx_data = next_tx;
    clock_bit(nack, r);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    checks++;
    if ({sda_oe, scl_oe, hs.rx_valid, hs.tx_req, addressed, rd_nwr, start_det, stop_det} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: got %b, expected 00000000",
               {sda_oe, scl_oe, hs.rx_valid, hs.tx_req, addressed, rd_nwr, start_det, stop_det});
    end
    checks++;
    if (hs.rx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_rx_data: got %h, expected 00", hs.rx_data);
    end
    reset_n = 1'b1;
    enable = 1'b1;
    tick(5);
  endtask

  // Write transfer: ACKs and rx_valid bytes follow from address match and rx_ready.
  task automatic test_write(input logic [6:0] own, input logic [6:0] a7,
                            input logic [7:0] data[$], input logic rdy);
    logic match, ack;
    int b_rx = rx_log.size(), b_st = n_start, b_sp = n_stop, b_sda = n_sda, b_ad = n_addr;
    match = (a7 == own);
    own_addr = own;
    hs.rx_ready = rdy;
    start_cond();
    write_byte({a7, 1'b0}, ack);
    checks++;
    if (ack !== ~match) begin
      failures++;
      $display("FAIL write_addr_ack: addr=%h own=%h ack_bit=%b expected %b", a7, own, ack, ~match);
    end
    checks++;
    if (addressed !== match) begin
      failures++;
      $display("FAIL write_addressed: got %b expected %b", addressed, match);
    end
    foreach (data[i]) begin
      write_byte(data[i], ack);
      checks++;
      if (ack !== ~(match & rdy)) begin
        failures++;
        $display("FAIL write_data_ack: byte %0d ack_bit=%b expected %b", i, ack, ~(match & rdy));
      end
    end
    stop_cond();
    tick(5);
    hs.rx_ready = 1'b1;
    checks++;
    if (rx_log.size() - b_rx !== (match ? data.size() : 0)) begin
      failures++;
      $display("FAIL write_rx_count: got %0d expected %0d", rx_log.size() - b_rx, match ? data.size() : 0);
    end else if (match) begin
      foreach (data[i]) begin
        checks++;
        if (rx_log[b_rx + i] !== data[i]) begin
          failures++;
          $display("FAIL write_rx_data: byte %0d got %h expected %h", i, rx_log[b_rx + i], data[i]);
        end
      end
    end
    checks++;
    if (n_start - b_st !== 1 || n_stop - b_sp !== 1) begin
      failures++;
      $display("FAIL write_start_stop: start=%0d stop=%0d expected 1 1", n_start - b_st, n_stop - b_sp);
    end
    if (!match) begin
      checks++;
      if (n_sda - b_sda !== 0 || n_addr - b_ad !== 0) begin
        failures++;
        $display("FAIL ignore_quiet: sda_oe cycles=%0d addressed cycles=%0d expected 0 0",
                 n_sda - b_sda, n_addr - b_ad);
      end
    end
    checks++;
    if (addressed !== 1'b0) begin
      failures++;
      $display("FAIL write_addressed_after_stop: got %b expected 0", addressed);
    end
  endtask

  // Read transfer: controller ACKs all but the last byte, then clocks one more byte.
  task automatic test_read(input logic [6:0] own, input logic [6:0] a7, input logic [7:0] data[$]);
    logic match, ack;
    logic [7:0] d, exp;
    int b_tx = n_txreq;
    match = (a7 == own);
    own_addr = own;
    hs.tx_data = data[0];
    start_cond();
    write_byte({a7, 1'b1}, ack);
    checks++;
    if (ack !== ~match || (match && rd_nwr !== 1'b1)) begin
      failures++;
      $display("FAIL read_addr: ack_bit=%b rd_nwr=%b expected ack_bit %b", ack, rd_nwr, ~match);
    end
    foreach (data[i]) begin
      read_byte(i == data.size() - 1, (i + 1 < data.size()) ? data[i + 1] : 8'h00, d);
      exp = match ? data[i] : 8'hFF;
      checks++;
      if (d !== exp) begin
        failures++;
        $display("FAIL read_data: byte %0d got %h expected %h", i, d, exp);
      end
    end
    read_byte(1'b1, 8'h00, d);
    checks++;
    if (d !== 8'hFF) begin
      failures++;
      $display("FAIL read_after_nack: got %h expected ff", d);
    end
    stop_cond();
    tick(5);
    checks++;
    if (n_txreq - b_tx !== (match ? data.size() : 0)) begin
      failures++;
      $display("FAIL read_tx_req: got %0d expected %0d", n_txreq - b_tx, match ? data.size() : 0);
    end
  endtask

  task automatic test_rep_start();
    logic ack;
    logic [7:0] d;
    int b_st = n_start, b_rx = rx_log.size();
    own_addr = 7'h50;
    hs.tx_data = 8'h6B;
    start_cond();
    write_byte({7'h50, 1'b0}, ack);
    write_byte(8'hE1, ack);
    start_cond();
    write_byte({7'h50, 1'b1}, ack);
    checks++;
    if (ack !== 1'b0 || rd_nwr !== 1'b1 || addressed !== 1'b1 || n_start - b_st !== 2) begin
      failures++;
      $display("FAIL rep_start: ack_bit=%b rd_nwr=%b addressed=%b starts=%0d expected 0 1 1 2",
               ack, rd_nwr, addressed, n_start - b_st);
    end
    read_byte(1'b1, 8'h00, d);
    stop_cond();
    tick(5);
    checks++;
    if (d !== 8'h6B || rx_log.size() - b_rx !== 1 || rx_log[b_rx] !== 8'hE1) begin
      failures++;
      $display("FAIL rep_start_data: read=%h rx_count=%0d expected 6b 1 (rx e1)", d, rx_log.size() - b_rx);
    end
  endtask

  task automatic test_enable_drop();
    logic ack, r;
    int b_sp, b_rx;
    own_addr = 7'h50;
    start_cond();
    write_byte({7'h50, 1'b0}, ack);
    for (int i = 7; i >= 0; i--) clock_bit(i[0], r);
    tick(12);
    checks++;
    if (sda_oe !== 1'b1) begin
      failures++;
      $display("FAIL drop_pre_ack: sda_oe=%b expected 1", sda_oe);
    end
    enable = 1'b0;
    b_sp = n_stop;
    b_rx = rx_log.size();
    tick(1);
    checks++;
    if (sda_oe !== 1'b0 || scl_oe !== 1'b0 || addressed !== 1'b0) begin
      failures++;
      $display("FAIL drop_release: sda_oe=%b scl_oe=%b addressed=%b expected 0 0 0", sda_oe, scl_oe, addressed);
    end
    clock_bit(1'b1, r);
    stop_cond();
    checks++;
    if (r !== 1'b1 || n_stop - b_sp !== 0 || rx_log.size() - b_rx !== 0) begin
      failures++;
      $display("FAIL drop_quiet: ack_bit=%b stops=%0d rx=%0d expected 1 0 0", r, n_stop - b_sp, rx_log.size() - b_rx);
    end
    enable = 1'b1;
    tick(5);
  endtask

`ifdef I2C_TARGET_STRETCH_EN
  task automatic test_stretch();
    logic ack;
    logic [7:0] d;
    own_addr = 7'h50;
    hs.tx_valid = 1'b0;
    hs.tx_data = 8'hC3;
    start_cond();
    write_byte({7'h50, 1'b1}, ack);
    tick(70);
    hs.tx_valid = 1'b1;
    read_byte(1'b1, 8'h00, d);
    stop_cond();
    tick(5);
    checks++;
    if (d !== 8'hC3 || max_run < 50) begin
      failures++;
      $display("FAIL stretch: data=%h longest scl_oe=%0d expected c3 and >=50", d, max_run);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] q[$];
    logic [6:0] own, a7;
    for (int k = 0; k < 8; k++) begin
      own = 7'($urandom);
      a7 = ($urandom_range(0, 1) == 1) ? own : (own ^ 7'($urandom_range(1, 127)));
      q.delete();
      for (int j = 0; j < $urandom_range(1, 3); j++) q.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) test_write(own, a7, q, 1'b1);
      else test_read(own, a7, q);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    hs.rx_ready = 1'b1;
    hs.tx_valid = 1'b1;
    hs.tx_data = 8'h00;
    test_reset();
    q = {8'hA5, 8'h3C};
    test_write(7'h50, 7'h50, q, 1'b1);
    q = {8'hA5};
    test_write(7'h50, 7'h51, q, 1'b1);
    q = {8'h96, 8'h0F};
    test_read(7'h50, 7'h50, q);
`ifndef I2C_TARGET_STRETCH_EN
    q = {8'h5A};
    test_write(7'h50, 7'h50, q, 1'b0);
`endif
    test_rep_start();
    test_enable_drop();
`ifdef I2C_TARGET_STRETCH_EN
    test_stretch();
`else
    checks++;
    if (max_run !== 0) begin
      failures++;
      $display("FAIL scl_oe_tied: scl_oe high for %0d clk, expected 0", max_run);
    end
`endif
    test_random();
    checks++;
    if (n_viol !== 0) begin
      failures++;
      $display("FAIL sda_while_scl_high: %0d changes, expected 0", n_viol);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
